// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the seven-segment display driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, active-low segment patterns {g,f,e,d,c,b,a},
//           and pow10() for building the overflow threshold at elaboration.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // 10^n in 64 bits; n <= 8 in practice, so no overflow concern.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Latency: start accepted at edge N -> busy for DATA_W+1 cycles, done (COMMIT) in the last one.
// Backpressure: start is only honoured in IDLE; starts while busy are dropped, not queued.
// Ports: clk, reset (sync, active-high), start, bin[DATA_W], busy, done (1-cycle, COMMIT),
//        bcd[4*DIGITS] (low DIGITS BCD digits; valid while done=1).
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BCD_W+DATA_W-1:0] shifted;
  logic                 last_shift;

  assign last_shift = (cnt_q == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start)      state_d = ST_SHIFT;
      ST_SHIFT:  if (last_shift) state_d = ST_COMMIT;
      ST_COMMIT:                 state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_COMMIT);
  end

  // Datapath. Only the low DIGITS nibbles are kept: carries in double dabble
  // only move upward, so truncating the top never corrupts the kept digits.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      bcd_d = shifted[BCD_W+DATA_W-1:DATA_W];
      bin_d = shifted[DATA_W-1:0];
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/display_mux.sv
// display_mux: captures a binary word, converts it to BCD and scans it onto a
//   multiplexed active-low seven-segment display (dashes + overflow when >= 10^DIGITS).
// Latency: load accepted at edge N -> busy DATA_W+1 cycles, new digits shown as busy drops.
// Backpressure: load is accepted only while busy=0; loads during a conversion are dropped.
// Ports: clk, reset (sync, active-high), data_in[DATA_W], load, busy, overflow,
//        segments[7] {g,f,e,d,c,b,a} active-low, anodes[DIGITS] one-hot active-low (bit0 = LSD).
// Build option: define DISPLAY_LZB_EN for leading-zero blanking (digit 0 never blanked).
module display_mux
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                load,
  output logic                busy,
  output logic                overflow,
  output logic [6:0]          segments,
  output logic [DIGITS-1:0]   anodes
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  logic                  conv_busy, conv_done, start;
  logic [4*DIGITS-1:0]   conv_bcd;

  logic                  ovf_pend_q, ovf_pend_d;
  logic                  overflow_q, overflow_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  scan_wrap;
  logic [3:0]            cur_nib;
  logic [6:0]            seg_dec;
  logic                  lead_zero;

  assign start = load & ~conv_busy;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (data_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Overflow is decided on the raw input, since the converter keeps only DIGITS nibbles.
  always_comb begin
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    disp_d     = disp_q;
    if (start) begin
      ovf_pend_d = (64'(data_in) >= OVF_LIMIT);
    end
    if (conv_done) begin
      disp_d     = conv_bcd;
      overflow_d = ovf_pend_q;
    end
  end

  // Free-running scan: each digit lit for SCAN_DIV cycles.
  assign scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    scan_d = scan_wrap ? '0 : scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      disp_q     <= '0;
      scan_q     <= '0;
      idx_q      <= '0;
    end else begin
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
    end
  end

  // Select and decode the nibble of the currently lit digit.
  always_comb begin
    cur_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        cur_nib = disp_q[4*i +: 4];
      end
    end
    seg_dec = (cur_nib < 4'd10) ? SEG_DIGIT[cur_nib] : SEG_BLANK;
  end

`ifdef DISPLAY_LZB_EN
  // Blank when this digit and every higher digit are zero; digit 0 always shows.
  always_comb begin
    lead_zero = (idx_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) >= idx_q && disp_q[4*i +: 4] != 4'd0) begin
        lead_zero = 1'b0;
      end
    end
  end
`else
  assign lead_zero = 1'b0;
`endif

  assign segments = overflow_q ? SEG_DASH : (lead_zero ? SEG_BLANK : seg_dec);
  assign anodes   = ~(DIGITS'(1) << idx_q);
  assign busy     = conv_busy;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: directed + random conversions checked against a decimal-arithmetic model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_display_mux;

  localparam int DIGITS   = 4;
  localparam int DATA_W   = 32;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] DIG [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              overflow;
  logic [6:0]        segments;
  logic [DIGITS-1:0] anodes;

  int total = 0;
  int bad   = 0;
  int k     = 0;            // non-reset edges since last reset edge

  logic [31:0] m_val;       // value the display should currently hold
  logic        m_ovf;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  display_mux #(
    .DIGITS   (DIGITS),
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .segments (segments),
    .anodes   (anodes)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int idx);
    int unsigned p;
    int unsigned dgt;
    p = 1;
    for (int j = 0; j < idx; j++) p = p * 10;
    dgt = (m_val / p) % 10;
    if (m_ovf) return 7'b0111111;
`ifdef DISPLAY_LZB_EN
    if (idx > 0 && m_val < p) return 7'b1111111;
`endif
    return DIG[dgt];
  endfunction

  task automatic check_disp(input string tag);
    int         idx;
    logic [3:0] ea;
    logic [6:0] es;
    idx = (k / SCAN_DIV) % DIGITS;
    ea  = ~(4'b0001 << idx);
    es  = exp_seg(idx);
    check({tag, ":anodes"},   32'(anodes),   32'(ea));
    check({tag, ":segments"}, 32'(segments), 32'(es));
    check({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic frame(input string tag, input int frames);
    repeat (frames * DIGITS * SCAN_DIV) begin
      check_disp(tag);
      @(negedge clk);
    end
  endtask

  task automatic convert(input logic [31:0] v);
    int n;
    wait_idle();
    load    = 1'b1;
    data_in = v;
    @(negedge clk);
    load    = 1'b0;
    data_in = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      check_disp("hold_old");
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(DATA_W + 1));
    m_val = v;
    m_ovf = (v >= 32'd10000);
    frame("frame", 1);
  endtask

  initial begin : main
    int          n;
    int          r;
    int          cyc;
    int          rises [3];
    logic        prev_b;
    logic [31:0] d;
    logic [31:0] last_acc;

    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    m_val   = 0;
    m_ovf   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_anodes",   32'(anodes),   32'b1110);
    check("rst_segments", 32'(segments), 32'b1000000);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idx0_still", 32'(anodes), 32'b1110);
    @(negedge clk);
    check("idx1_after4", 32'(anodes), 32'b1101);
    frame("rst_frame", 2);

    // Directed values including overflow boundaries
    convert(32'd1234);
    convert(32'd10000);
    convert(32'd9999);
    convert(32'd0);
    convert(32'd7);
    convert(32'd1050);
    convert(32'hFFFF_FFFF);

    // Busy rejection: second load three cycles in is dropped and not queued
    wait_idle();
    load    = 1'b1;
    data_in = 32'd5;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 2) begin
        load    = 1'b1;
        data_in = 32'd9;
      end else begin
        load = 1'b0;
      end
      check_disp("rej_hold");
      n++;
      @(negedge clk);
    end
    load = 1'b0;
    check("rej_busy_cycles", 32'(n), 32'(DATA_W + 1));
    m_val = 5;
    m_ovf = 1'b0;
    repeat (DIGITS * SCAN_DIV) begin
      check("rej_no_requeue", 32'(busy), 32'd0);
      check_disp("rej_frame");
      @(negedge clk);
    end

    // Reset mid-conversion: 42 must never appear
    convert(32'd9876);
    wait_idle();
    load    = 1'b1;
    data_in = 32'd42;
    @(negedge clk);
    load = 1'b0;
    repeat (10) begin
      check_disp("mid_hold");
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    m_val = 0;
    m_ovf = 1'b0;
    check("mid_busy",     32'(busy),     32'd0);
    check("mid_overflow", 32'(overflow), 32'd0);
    check("mid_anodes",   32'(anodes),   32'b1110);
    check("mid_segments", 32'(segments), 32'b1000000);
    reset = 1'b0;
    repeat (2 * DIGITS * SCAN_DIV) begin
      check("mid_no_busy", 32'(busy), 32'd0);
      check_disp("mid_frame");
      @(negedge clk);
    end

    // Load held high: restart period and last accepted value
    wait_idle();
    load     = 1'b1;
    r        = 0;
    cyc      = 0;
    prev_b   = 1'b0;
    last_acc = '0;
    rises    = '{0, 0, 0};
    while (r < 3 && cyc < 300) begin
      if (busy === 1'b1 && !prev_b) begin
        rises[r] = cyc;
        r++;
      end
      prev_b = busy;
      if (r < 3) begin
        d       = $urandom_range(0, 20000);
        data_in = d;
        if (busy === 1'b0) last_acc = d;
      end else begin
        load = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    load = 1'b0;
    check("hold_rises",   32'(r),                   32'd3);
    check("hold_period1", 32'(rises[1] - rises[0]), 32'(DATA_W + 2));
    check("hold_period2", 32'(rises[2] - rises[1]), 32'(DATA_W + 2));
    wait_idle();
    m_val = last_acc;
    m_ovf = (last_acc >= 32'd10000);
    frame("hold_frame", 1);

    // Random values, mixing in-range and full-width
    repeat (10) begin
      if ($urandom_range(0, 1) == 1) convert($urandom_range(0, 9999));
      else                           convert($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
